// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_pkg
//  Description : Shared constants, state encoding and helpers for the UART
//                frame controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

    localparam logic [7:0] ACK_BYTE      = 8'h06;
    localparam logic [7:0] NAK_BYTE      = 8'h15;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Frame controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    // Response byte for a frame decision
    function automatic logic [7:0] resp_byte(input logic ack);
        return ack ? ACK_BYTE : NAK_BYTE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_ctrl_if
//  Description : Byte-stream, transmitter and payload handshake signals of
//                the UART frame controller. The controller uses the slave
//                view; the surrounding system uses the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_ctrl_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       pl_last;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  rx_data, rx_valid, tx_busy, pl_ready,
        output tx_data, tx_start, pl_data, pl_valid, pl_last, frame_err, busy
    );

    modport master (
        output rx_data, rx_valid, tx_busy, pl_ready,
        input  tx_data, tx_start, pl_data, pl_valid, pl_last, frame_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/frame_buf.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf
//  Description : Payload storage, one synchronous write port and one
//                asynchronous read port. The array carries no reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic          clk,
    input  wire logic          wr_en,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [7:0]    wr_data,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [7:0]    rd_data
);

    logic [7:0] r_mem [DEPTH];

    // Write received payload bytes
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_ctrl
//  Description : Receives SYNC/LEN/payload/CHK frames from a UART byte
//                stream, checks length and XOR checksum, streams accepted
//                payload out under valid/ready and answers ACK or NAK.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    uart_frame_ctrl_if.slave   bus
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0]    c_len_max = 8'(MAX_LEN);
    localparam logic [TW-1:0] c_tmo_max = TW'(TIMEOUT_CYC);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_cnt;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_xor;
    logic [7:0]    r_tx_data;
    logic [7:0]    r_pl_data;
    logic          r_pl_valid;
    logic          r_pl_last;

    logic          w_timed;
    logic          w_tmo_exp;
    logic          w_rx;
    logic          w_len_ok;
    logic          w_nak;
    logic          w_pl_accept;
    logic          w_pl_load;
    logic          w_ack_done;
    logic          w_wr_en;
    logic [7:0]    w_rd_data;

    // Payload buffer: written in PAYLOAD, read while draining, both at r_cnt
    frame_buf #(
        .DEPTH (16),
        .AW    (4)
    ) u_buf (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (4'(r_cnt)),
        .wr_data (bus.rx_data),
        .rd_addr (4'(r_cnt)),
        .rd_data (w_rd_data)
    );

    // Qualifiers shared by the next-state logic and the datapath
    always_comb begin
        w_timed     = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
        // A byte arriving in the expiry cycle loses to the timeout
        w_tmo_exp   = w_timed && (r_tmo == c_tmo_max);
        w_rx        = bus.rx_valid && !w_tmo_exp;
        w_len_ok    = (bus.rx_data != 8'h00) && (bus.rx_data <= c_len_max);
        w_pl_accept = r_pl_valid && bus.pl_ready;
        w_ack_done  = (r_state == ST_DRAIN) && w_pl_accept && r_pl_last;
        w_pl_load   = (r_state == ST_DRAIN) && (!r_pl_valid || (w_pl_accept && !r_pl_last));
        w_wr_en     = (r_state == ST_PAYLOAD) && w_rx;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and NAK decision
    always_comb begin
        w_state_nxt = r_state;
        w_nak       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_tmo_exp) begin
                    w_state_nxt = ST_RESP;
                    w_nak       = 1'b1;
                end else if (w_rx) begin
                    if (w_len_ok) begin
                        w_state_nxt = ST_PAYLOAD;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_nak       = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_tmo_exp) begin
                    w_state_nxt = ST_RESP;
                    w_nak       = 1'b1;
                end else if (w_rx && ((r_cnt + LW'(1)) == r_len)) begin
                    w_state_nxt = ST_CHK;
                end
            end
            ST_CHK: begin
                if (w_tmo_exp) begin
                    w_state_nxt = ST_RESP;
                    w_nak       = 1'b1;
                end else if (w_rx) begin
                    if (bus.rx_data == r_xor) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_nak       = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_ack_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!bus.tx_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Idle timer: restarts on every received byte and on each state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (!w_timed || (w_state_nxt != r_state) || bus.rx_valid) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    // Frame datapath: length, byte counter, running XOR and payload output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_cnt      <= '0;
            r_xor      <= 8'h00;
            r_pl_data  <= 8'h00;
            r_pl_valid <= 1'b0;
            r_pl_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_LEN: begin
                    if (w_rx && w_len_ok) begin
                        r_len <= LW'(bus.rx_data);
                        r_cnt <= '0;
                        r_xor <= bus.rx_data;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_rx) begin
                        r_xor <= r_xor ^ bus.rx_data;
                        r_cnt <= r_cnt + LW'(1);
                    end
                end
                ST_CHK: begin
                    if (w_rx && (bus.rx_data == r_xor)) begin
                        r_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_pl_load) begin
                        r_pl_data  <= w_rd_data;
                        r_pl_last  <= (r_cnt == (r_len - LW'(1)));
                        r_pl_valid <= 1'b1;
                        r_cnt      <= r_cnt + LW'(1);
                    end else if (w_ack_done) begin
                        r_pl_valid <= 1'b0;
                        r_pl_last  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Response byte is latched on entry to RESP and held through tx_start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data <= 8'h00;
        end else if ((r_state != ST_RESP) && (w_state_nxt == ST_RESP)) begin
            r_tx_data <= resp_byte(!w_nak);
        end
    end

    assign bus.tx_data   = r_tx_data;
    assign bus.tx_start  = (r_state == ST_RESP) && !bus.tx_busy;
    assign bus.pl_data   = r_pl_data;
    assign bus.pl_valid  = r_pl_valid;
    assign bus.pl_last   = r_pl_last;
    assign bus.frame_err = w_nak;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_ctrl
//  Description : Self-checking bench for uart_frame_ctrl with a frame-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_ctrl;

    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 100;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam logic [7:0] ACK     = 8'h06;
    localparam logic [7:0] NAK     = 8'h15;

    logic clk = 1'b0;
    logic rst_n;

    uart_frame_ctrl_if bus ();

    uart_frame_ctrl #(
        .SYNC_BYTE   (SYNC),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] frame_q [$];
    logic [7:0] exp_pl  [$];
    logic       exp_last[$];
    logic [7:0] exp_tx  [$];
    int         exp_err;

    logic [7:0] got_pl  [$];
    logic       got_last[$];
    logic [7:0] got_tx  [$];
    int         got_err;
    int         stall_viol;
    int         txb_viol;
    int         cyc;
    int         last_acc_cyc;
    int         tx_cyc;
    int         rdy_mode;

    // Observation of the DUT on the falling edge
    initial begin
        logic       p_valid;
        logic       p_ready;
        logic [7:0] p_data;
        p_valid = 1'b0; p_ready = 1'b0; p_data = 8'h00;
        cyc = 0; got_err = 0; stall_viol = 0; txb_viol = 0;
        last_acc_cyc = 0; tx_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (bus.pl_valid && bus.pl_ready) begin
                    got_pl.push_back(bus.pl_data);
                    got_last.push_back(bus.pl_last);
                    last_acc_cyc = cyc;
                end
                if (bus.tx_start) begin
                    got_tx.push_back(bus.tx_data);
                    tx_cyc = cyc;
                    if (bus.tx_busy) txb_viol++;
                end
                if (bus.frame_err) got_err++;
                if (p_valid && !p_ready && (!bus.pl_valid || bus.pl_data !== p_data)) stall_viol++;
                p_valid = bus.pl_valid;
                p_ready = bus.pl_ready;
                p_data  = bus.pl_data;
            end else begin
                p_valid = 1'b0;
            end
        end
    end

    // Consumer: always ready, random, or five stall cycles per byte
    initial begin
        int stall;
        stall = 0;
        bus.pl_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: bus.pl_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (bus.pl_valid) begin
                        if (stall < 5) begin
                            bus.pl_ready = 1'b0;
                            stall++;
                        end else begin
                            bus.pl_ready = 1'b1;
                            stall = 0;
                        end
                    end else begin
                        bus.pl_ready = 1'b0;
                        stall = 0;
                    end
                end
                default: bus.pl_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (gap) tick();
    endtask

    task automatic clear_obs();
        got_pl.delete(); got_last.delete(); got_tx.delete(); got_err = 0;
        exp_pl.delete(); exp_last.delete(); exp_tx.delete(); exp_err = 0;
    endtask

    // Frame-level model: decide from length and XOR checksum what must come out
    task automatic model_frame();
        int         len;
        logic [7:0] x;
        len = int'(frame_q[1]);
        if (len == 0 || len > MAX_LEN) begin
            exp_tx.push_back(NAK);
            exp_err++;
            return;
        end
        x = frame_q[1];
        for (int i = 0; i < len; i++) x = x ^ frame_q[2 + i];
        if (frame_q[2 + len] == x) begin
            for (int i = 0; i < len; i++) begin
                exp_pl.push_back(frame_q[2 + i]);
                exp_last.push_back(i == len - 1);
            end
            exp_tx.push_back(ACK);
        end else begin
            exp_tx.push_back(NAK);
            exp_err++;
        end
    endtask

    task automatic build_frame(input int len, input logic corrupt);
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(SYNC);
        frame_q.push_back(8'(len));
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            x = x ^ b;
        end
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        frame_q.push_back(x);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_done"}, (n < 2000), 1'b1);
        tick();
    endtask

    task automatic compare(input string tag);
        check({tag, "_pl_count"}, got_pl.size(), exp_pl.size());
        for (int i = 0; i < exp_pl.size() && i < got_pl.size(); i++) begin
            check({tag, "_pl_data"}, got_pl[i], exp_pl[i]);
            check({tag, "_pl_last"}, got_last[i], exp_last[i]);
        end
        check({tag, "_tx_count"}, got_tx.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
            check({tag, "_tx_data"}, got_tx[i], exp_tx[i]);
        end
        check({tag, "_frame_err"}, got_err, exp_err);
        if (exp_pl.size() > 0 && got_tx.size() > 0) begin
            check({tag, "_ack_after_accept"}, (tx_cyc > last_acc_cyc), 1'b1);
        end
        clear_obs();
    endtask

    task automatic run_frame(input string tag, input int max_gap);
        model_frame();
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], $urandom_range(0, max_gap));
        end
        wait_done(tag);
        compare(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"},  bus.tx_start,  1'b0);
        check({tag, "_pl_valid"},  bus.pl_valid,  1'b0);
        check({tag, "_pl_last"},   bus.pl_last,   1'b0);
        check({tag, "_frame_err"}, bus.frame_err, 1'b0);
        check({tag, "_busy"},      bus.busy,      1'b0);
        check({tag, "_tx_data"},   bus.tx_data,   8'h00);
        check({tag, "_pl_data"},   bus.pl_data,   8'h00);
    endtask

    initial begin
        rst_n        = 1'b0;
        rdy_mode     = 0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_busy  = 1'b0;
        clear_obs();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Good frame, consumer always ready
        frame_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        run_frame("good3", 0);

        // Bad checksum
        frame_q = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
        run_frame("badchk", 0);

        // Illegal lengths
        frame_q = '{8'hA5, 8'h00};
        run_frame("len0", 0);
        frame_q = '{8'hA5, 8'h11};
        run_frame("len17", 0);

        // Backpressure: five stall cycles per byte
        rdy_mode = 2;
        stall_viol = 0;
        build_frame(4, 1'b0);
        run_frame("stall4", 1);
        check("stall_stable", stall_viol, 0);
        rdy_mode = 0;

        // Maximum length frame
        build_frame(MAX_LEN, 1'b0);
        run_frame("max_len", 2);

        // Timeout with the transmitter busy across the expiry
        frame_q = '{8'hA5, 8'h02, 8'h10};
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 0);
        exp_tx.push_back(NAK);
        exp_err = 1;
        repeat (90) tick();
        check("tmo_no_early_tx", got_tx.size(), 0);
        check("tmo_busy", bus.busy, 1'b1);
        bus.tx_busy = 1'b1;
        txb_viol = 0;
        repeat (20) tick();
        check("tmo_tx_held_off", got_tx.size(), 0);
        check("tmo_err_seen", got_err, 1);
        bus.tx_busy = 1'b0;
        wait_done("tmo");
        compare("tmo");
        check("tmo_tx_while_busy", txb_viol, 0);
        build_frame(2, 1'b0);
        run_frame("after_tmo", 1);

        // Reset in the middle of the payload
        build_frame(4, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(frame_q[i], 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) tick();
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        repeat (10) tick();
        check("midrst_no_resp", got_tx.size(), 0);
        check("midrst_no_pl", got_pl.size(), 0);
        clear_obs();
        build_frame(3, 1'b0);
        run_frame("after_rst", 0);

        // Random mix of good, corrupt and illegal-length frames
        for (int k = 0; k < 12; k++) begin
            int kind;
            kind = $urandom_range(0, 3);
            rdy_mode = $urandom_range(0, 1);
            if (kind <= 1) begin
                build_frame($urandom_range(1, MAX_LEN), 1'b0);
            end else if (kind == 2) begin
                build_frame($urandom_range(1, MAX_LEN), 1'b1);
            end else begin
                frame_q.delete();
                frame_q.push_back(SYNC);
                frame_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
            end
            run_frame("rand", 3);
        end
        rdy_mode = 0;
        check("final_stall_stable", stall_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter MAX_LEN, default 16, maximum payload bytes; legal range 1..16.
REQ-003 Parameter TIMEOUT_CYC, default 200000, idle clocks allowed between bytes inside a frame.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rx_data  input  8  byte from UART receiver; valid only when rx_valid is high.
REQ-007 rx_valid  input  1  one-cycle strobe, one received byte.
REQ-008 tx_busy  input  1  UART transmitter busy; high from the cycle after tx_start until the stop bit ends.
REQ-009 tx_data  output  8  byte to transmit; held stable while tx_start is high.
REQ-010 tx_start  output  1  one-cycle request to transmit tx_data.
REQ-011 pl_data  output  8  payload byte to the neural-network input stage.
REQ-012 pl_valid  output  1  pl_data valid; held until accepted.
REQ-013 pl_ready  input  1  consumer accepts pl_data when pl_valid and pl_ready are both high.
REQ-014 pl_last  output  1  high with the final payload byte of a frame.
REQ-015 frame_err  output  1  one-cycle pulse for each rejected frame.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK; CHK is the XOR of LEN and all payload bytes.
REQ-018 States: IDLE, LEN, PAYLOAD, CHK, DRAIN, RESP.
- IDLE -> LEN on rx_valid with rx_data == SYNC_BYTE.
- Any other byte in IDLE is discarded silently.
REQ-019 LEN state:
- LEN == 0 or LEN > MAX_LEN -> RESP with NAK.
- Otherwise store LEN, clear the byte counter, seed the running XOR with LEN, go to PAYLOAD.
REQ-020 PAYLOAD: each rx_valid writes rx_data to buffer[count], updates the XOR and increments count; when count reaches LEN -> CHK.
REQ-021 CHK: on rx_valid, a byte equal to the running XOR -> DRAIN; a mismatch -> RESP with NAK.
REQ-022 DRAIN: buffer bytes 0..LEN-1 are presented in order on pl_data under the valid/ready handshake.
- pl_last asserts with byte LEN-1.
- The first pl_valid is no later than 1 cycle after entering DRAIN.
- With pl_ready tied high, one byte is accepted per cycle.
- After the last accept -> RESP with ACK.
REQ-023 No payload byte from a rejected frame ever appears on pl_valid.
REQ-024 RESP:
- Load tx_data with 8'h06 (ACK) or 8'h15 (NAK).
- Pulse tx_start for one cycle in the first cycle tx_busy is low.
- Return to IDLE the next cycle.
REQ-025 frame_err pulses in the cycle a NAK decision is made.
REQ-026 Timeout: in LEN, PAYLOAD or CHK, TIMEOUT_CYC consecutive cycles without rx_valid -> RESP with NAK.
- The timeout counter clears on every rx_valid and on state entry.
REQ-027 rx_valid in DRAIN or RESP: the byte is dropped and has no other effect.
REQ-028 rx_valid in the same cycle as a timeout expiry: the timeout takes priority and the byte is dropped.
REQ-029 pl_valid must not deassert, and pl_data must not change, while pl_valid is high and pl_ready is low.

Reset
REQ-030 While rst_n is low:
- State = IDLE.
- tx_start, pl_valid, pl_last, frame_err, busy = 0.
- tx_data and pl_data = 8'h00.
- All counters and the running XOR = 0.
REQ-031 Reset asserted mid-frame or mid-DRAIN abandons the frame; no ACK/NAK is sent after reset release.

Structure
REQ-032 Shared package uart_frame_pkg holds:
- constants ACK_BYTE 8'h06, NAK_BYTE 8'h15, default SYNC_BYTE;
- the state encoding.
REQ-033 Payload storage is a sub-module frame_buf: 16x8, one synchronous write port, one read port, no reset on the storage array.
REQ-034 The byte counter, LEN register and timeout counter are sized from MAX_LEN and TIMEOUT_CYC using clog2.

Verification
REQ-035 Good frame: rx A5 03 11 22 33 03, pl_ready = 1 -> pl_data 11, 22, 33 with pl_last on 33, then tx_start with tx_data 06.
REQ-036 Bad checksum: rx A5 02 AA 55 00 -> no pl_valid, frame_err pulse, tx_start with tx_data 15.
REQ-037 Illegal length: rx A5 00, then A5 11 with MAX_LEN = 16 -> two NAKs, no pl_valid.
REQ-038 Backpressure: good 4-byte frame, pl_ready low for 5 cycles per byte -> data stable while stalled, order preserved, ACK only after the last accept.
REQ-039 Timeout and busy TX: rx A5 02 10, then silence for TIMEOUT_CYC (set to 100) with tx_busy held high for 20 cycles -> NAK tx_start delayed until tx_busy falls, then IDLE; a following good frame is accepted.
REQ-040 Reset mid-PAYLOAD: rst_n low for 3 cycles -> all outputs at reset values, no response sent, next good frame works.
